// File: rtl/mii_tx_ctrl.sv
// MII transmit frame controller.
// Sits between the MII TX pin block and the 4B/5B encoder: delimits frames,
// applies jabber protection and sequences isolate entry/exit on nibble
// boundaries so a frame is never joined or truncated without being flagged.
// All state advances only on cycles where the nibble strobe ce is high; every
// output is registered, so responses appear one clk after the ce that caused them.
module mii_tx_ctrl #(
  parameter int unsigned JABBER_NIBBLES = 4096,
  parameter int unsigned UNJAB_NIBBLES  = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       isolate_req,
  input  logic       ce,
  input  logic       enable,
  input  logic       err,
  input  logic [3:0] data,
  output logic       isolate,
  output logic       tx_valid,
  output logic [3:0] tx_data,
  output logic       tx_err,
  output logic       tx_sof,
  output logic       tx_eof,
  output logic       jabber,
  input  logic       jabber_clr
);

  // One counter serves both the in-frame nibble count and the jabber idle
  // count; it is sized for the larger of the two limits.
  localparam int unsigned MaxLim =
      (JABBER_NIBBLES > UNJAB_NIBBLES) ? JABBER_NIBBLES : UNJAB_NIBBLES;
  localparam int unsigned CntW   = $clog2(MaxLim + 1);

  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
  localparam logic [CntW-1:0] JabLim   = CntW'(JABBER_NIBBLES);
  localparam logic [CntW-1:0] UnjabLim = CntW'(UNJAB_NIBBLES);

  typedef enum logic [2:0] {
    StIsolated = 3'd0,
    StSync     = 3'd1,
    StIdle     = 3'd2,
    StFrame    = 3'd3,
    StJabber   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            isolate_q, isolate_d;
  logic            valid_q, valid_d;
  logic [3:0]      data_q, data_d;
  logic            err_q, err_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            jabber_q, jabber_d;

  // Saturating increment shared by both counting uses.
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    err_d    = 1'b0;
    data_d   = data_q;
    // Clear works every clk; a trip below overrides it (set wins).
    jabber_d = jabber_clr ? 1'b0 : jabber_q;

    if (ce) begin
      if ((state_q != StIsolated) && isolate_req) begin
        // Isolate takes priority; an open frame is closed and flagged.
        state_d = StIsolated;
        cnt_d   = '0;
        if (state_q == StFrame) begin
          eof_d = 1'b1;
          err_d = 1'b1;
        end
      end else begin
        unique case (state_q)
          StIsolated: begin
            if (!isolate_req) begin
              state_d = StSync;
              cnt_d   = '0;
            end
          end
          StSync: begin
            // Never start mid-frame: wait for a nibble time with TX_EN low.
            if (!enable) begin
              state_d = StIdle;
              cnt_d   = '0;
            end
          end
          StIdle: begin
            if (enable) begin
              state_d = StFrame;
              cnt_d   = CntW'(1);
              valid_d = 1'b1;
              sof_d   = 1'b1;
              data_d  = data;
              err_d   = err;
            end
          end
          StFrame: begin
            if (enable) begin
              if (cnt_inc >= JabLim) begin
                // Jabber trip: this nibble is dropped and the frame closed.
                state_d  = StJabber;
                cnt_d    = '0;
                eof_d    = 1'b1;
                err_d    = 1'b1;
                jabber_d = 1'b1;
              end else begin
                cnt_d   = cnt_inc;
                valid_d = 1'b1;
                data_d  = data;
                err_d   = err;
              end
            end else begin
              state_d = StIdle;
              cnt_d   = '0;
              eof_d   = 1'b1;
            end
          end
          StJabber: begin
            if (enable) begin
              cnt_d = '0;
            end else if (cnt_inc >= UnjabLim) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin
            state_d = StIsolated;
            cnt_d   = '0;
          end
        endcase
      end
    end

    isolate_d = (state_d == StIsolated);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIsolated;
      cnt_q     <= '0;
      isolate_q <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= 4'h0;
      err_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      jabber_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isolate_q <= isolate_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      err_q     <= err_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      jabber_q  <= jabber_d;
    end
  end

  assign isolate  = isolate_q;
  assign tx_valid = valid_q;
  assign tx_data  = data_q;
  assign tx_err   = err_q;
  assign tx_sof   = sof_q;
  assign tx_eof   = eof_q;
  assign jabber   = jabber_q;

endmodule

// File: tb/tb_mii_tx_ctrl.sv
// Directed bench for mii_tx_ctrl with a short jabber limit (16 nibbles).
module tb_mii_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       isolate_req;
  logic       ce;
  logic       enable;
  logic       err;
  logic [3:0] data;
  logic       isolate;
  logic       tx_valid;
  logic [3:0] tx_data;
  logic       tx_err;
  logic       tx_sof;
  logic       tx_eof;
  logic       jabber;
  logic       jabber_clr;

  int compared   = 0;
  int mismatched = 0;

  // Outputs captured one clk after the most recent ce.
  logic       o_valid, o_sof, o_eof, o_err, o_iso;
  logic [3:0] o_data;
  int         n_valid, n_sof, n_eof;

  mii_tx_ctrl #(
    .JABBER_NIBBLES(16),
    .UNJAB_NIBBLES (24)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .isolate_req(isolate_req),
    .ce         (ce),
    .enable     (enable),
    .err        (err),
    .data       (data),
    .isolate    (isolate),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_err     (tx_err),
    .tx_sof     (tx_sof),
    .tx_eof     (tx_eof),
    .jabber     (jabber),
    .jabber_clr (jabber_clr)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One nibble time: ce for one clk, capture outputs, check strobes drop.
  task automatic step(input logic en, input logic er, input logic [3:0] d, input logic clr);
    @(negedge clk);
    ce         = 1'b1;
    enable     = en;
    err        = er;
    data       = d;
    jabber_clr = clr;
    @(negedge clk);
    ce         = 1'b0;
    jabber_clr = 1'b0;
    o_valid = tx_valid;
    o_sof   = tx_sof;
    o_eof   = tx_eof;
    o_err   = tx_err;
    o_data  = tx_data;
    o_iso   = isolate;
    if (o_valid) n_valid++;
    if (o_sof)   n_sof++;
    if (o_eof)   n_eof++;
    @(negedge clk);
    chk1("strobe_width", tx_valid | tx_eof | tx_sof, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; isolate_req = 1'b0; ce = 1'b0; enable = 1'b0;
    err = 1'b0; data = 4'h0; jabber_clr = 1'b0;
    n_valid = 0; n_sof = 0; n_eof = 0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk1("rst_isolate", isolate, 1'b1);
    chk1("rst_valid", tx_valid, 1'b0);
    chk1("rst_sof", tx_sof, 1'b0);
    chk1("rst_eof", tx_eof, 1'b0);
    chk1("rst_err", tx_err, 1'b0);
    chkn("rst_data", int'(tx_data), 0);
    chk1("rst_jabber", jabber, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("iso_before_ce", isolate, 1'b1);

    // First ce leaves ISOLATED; second (enable low) reaches IDLE.
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk1("iso_drop", o_iso, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk1("sync_no_valid", o_valid, 1'b0);

    // Basic 3-nibble frame 5,5,D.
    step(1'b1, 1'b0, 4'h5, 1'b0);
    chk1("f1_n1_valid", o_valid, 1'b1);
    chk1("f1_n1_sof", o_sof, 1'b1);
    chkn("f1_n1_data", int'(o_data), 5);
    step(1'b1, 1'b0, 4'h5, 1'b0);
    chk1("f1_n2_valid", o_valid, 1'b1);
    chk1("f1_n2_sof", o_sof, 1'b0);
    step(1'b1, 1'b0, 4'hD, 1'b0);
    chk1("f1_n3_valid", o_valid, 1'b1);
    chkn("f1_n3_data", int'(o_data), 13);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk1("f1_eof", o_eof, 1'b1);
    chk1("f1_eof_valid", o_valid, 1'b0);
    chk1("f1_eof_err", o_err, 1'b0);

    // err while idle is ignored.
    step(1'b0, 1'b1, 4'h3, 1'b0);
    chk1("idle_err_valid", o_valid, 1'b0);
    chk1("idle_err_err", o_err, 1'b0);
    chk1("idle_err_eof", o_eof, 1'b0);

    // 4-nibble frame with err on nibble 2 only.
    step(1'b1, 1'b0, 4'h1, 1'b0);
    chk1("f2_n1_err", o_err, 1'b0);
    step(1'b1, 1'b1, 4'h2, 1'b0);
    chk1("f2_n2_err", o_err, 1'b1);
    chk1("f2_n2_valid", o_valid, 1'b1);
    chkn("f2_n2_data", int'(o_data), 2);
    step(1'b1, 1'b0, 4'h3, 1'b0);
    chk1("f2_n3_err", o_err, 1'b0);
    step(1'b1, 1'b0, 4'h4, 1'b0);
    chk1("f2_n4_err", o_err, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk1("f2_eof", o_eof, 1'b1);

    // Isolate, then release while TX_EN is held high.
    isolate_req = 1'b1;
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk1("iso2_set", o_iso, 1'b1);
    chk1("iso2_no_eof", o_eof, 1'b0);
    step(1'b1, 1'b0, 4'h7, 1'b0);
    chk1("iso2_hold", o_iso, 1'b1);
    isolate_req = 1'b0;
    n_valid = 0;
    step(1'b1, 1'b0, 4'h7, 1'b0);
    chk1("iso2_release", o_iso, 1'b0);
    step(1'b1, 1'b0, 4'h7, 1'b0);
    step(1'b1, 1'b0, 4'h7, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chkn("sync_midframe_valids", n_valid, 0);
    step(1'b1, 1'b0, 4'hA, 1'b0);
    chk1("sync_next_sof", o_sof, 1'b1);
    chkn("sync_next_data", int'(o_data), 10);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk1("sync_next_eof", o_eof, 1'b1);

    // Jabber: 20-nibble frame, limit 16.
    n_valid = 0; n_eof = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 4'(i), 1'b0);
      if (i == 16) begin
        chk1("jab_trip_eof", o_eof, 1'b1);
        chk1("jab_trip_err", o_err, 1'b1);
        chk1("jab_trip_valid", o_valid, 1'b0);
      end
    end
    chkn("jab_valids", n_valid, 15);
    chkn("jab_eofs", n_eof, 1);
    chk1("jab_set", jabber, 1'b1);
    n_valid = 0;
    for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h9, 1'b0);
    chkn("unjab_23_ignored", n_valid, 0);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h6, 1'b0);
    chk1("unjab_24_valid", o_valid, 1'b1);
    chk1("unjab_24_sof", o_sof, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0);
    chk1("unjab_eof", o_eof, 1'b1);
    chk1("jab_sticky", jabber, 1'b1);

    // jabber_clr alone clears next clk.
    @(negedge clk);
    jabber_clr = 1'b1;
    @(negedge clk);
    jabber_clr = 1'b0;
    chk1("jab_clr", jabber, 1'b0);

    // isolate_req at nibble 5 of a frame.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 4'(i), 1'b0);
    isolate_req = 1'b1;
    step(1'b1, 1'b0, 4'h5, 1'b0);
    chk1("iso_mid_eof", o_eof, 1'b1);
    chk1("iso_mid_err", o_err, 1'b1);
    chk1("iso_mid_valid", o_valid, 1'b0);
    chk1("iso_mid_isolate", o_iso, 1'b1);
    isolate_req = 1'b0;
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0);

    // Trip with simultaneous jabber_clr: set wins.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 4'(i), i == 16);
    chk1("clr_trip_eof", o_eof, 1'b1);
    chk1("clr_trip_jabber", jabber, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
